// File: rtl/mio_pkg.sv
// ============================================================================
// mio_pkg
//   Shared definitions for the MIO bus responder:
//     - FSM state encoding (IDLE, RAM_WAIT, IO_ACC, DONE)
//     - IO register offsets inside the IO page
//     - address-decode compare masks and the decode helper
// ============================================================================
package mio_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAM_WAIT = 2'd1;
    localparam logic [1:0] ST_IO_ACC   = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Register offsets within the IO page
    localparam logic [31:0] IO_SW_LED_OFS = 32'h0000_0000;
    localparam logic [31:0] IO_CNT_OFS    = 32'h0000_0004;

    // The IO page is 8 bytes: the page mask matches the page, the register
    // mask picks one of the two word registers (byte bits are ignored).
    localparam logic [31:0] IO_PAGE_MASK = 32'hFFFF_FFF8;
    localparam logic [31:0] IO_REG_MASK  = 32'h0000_0004;

    // Access target resolved at request time
    typedef enum logic [1:0] {
        TGT_RAM    = 2'd0,
        TGT_SW_LED = 2'd1,
        TGT_CNT    = 2'd2,
        TGT_NONE   = 2'd3
    } target_e;

    // Resolve a byte address to its target. The IO page is checked first so
    // an IO_BASE placed inside the RAM window still reaches the peripherals.
    function automatic target_e addr_decode(input logic [31:0] addr,
                                            input logic [31:0] io_base,
                                            input int          ram_aw);
        target_e tgt;
        if ((addr & IO_PAGE_MASK) == (io_base & IO_PAGE_MASK)) begin
            if ((addr & IO_REG_MASK) == IO_CNT_OFS) begin
                tgt = TGT_CNT;
            end else if ((addr & IO_REG_MASK) == IO_SW_LED_OFS) begin
                tgt = TGT_SW_LED;
            end else begin
                tgt = TGT_NONE;
            end
        end else if ((addr >> (ram_aw + 2)) == 32'd0) begin
            tgt = TGT_RAM;
        end else begin
            tgt = TGT_NONE;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mio_counter.sv
// ============================================================================
// mio_counter
//   Free-running 32-bit counter, +1 per clock, wrapping at 2^32. A load
//   replaces the increment for that cycle.
// Ports
//   clk       in   1   system clock
//   reset     in   1   synchronous active-high reset (count -> 0)
//   load      in   1   load enable
//   load_val  in   32  value loaded when load is high
//   count     out  32  current counter value
// ============================================================================
module mio_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count
);

    // Counter register: reset, load override, else increment (wraps naturally)
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// ============================================================================
// mio_bus_responder
//   Slave side of the CPU MIO handshake. A request (CPU_MIO & (MemRead |
//   MemWrite)) is sampled in IDLE, serviced from block RAM (RAM_WAIT) or the
//   on-chip IO page (IO_ACC), and answered with a one-cycle MIO_ready pulse.
//   IO page at IO_BASE: +0 switches (read) / LEDs (write),
//                       +4 counter (read) / counter reload (write).
//   Unmapped accesses still complete; reads return 0, writes are dropped.
//
//   Build option: define MIO_BUS_ERR_EN to make bus_err a sticky flag set on
//   completion of an unmapped access (cleared only by reset). Without it
//   bus_err is tied low.
//
// Ports
//   clk        in   1       system clock
//   reset      in   1       synchronous active-high reset
//   CPU_MIO    in   1       CPU owns the bus
//   MemRead    in   1       read request
//   MemWrite   in   1       write request (wins over MemRead)
//   Addr_in    in   32      byte address, bits [1:0] ignored
//   Data_in    in   32      write data
//   Data_out   out  32      read data, held until the next read completes
//   MIO_ready  out  1       one-cycle completion pulse
//   ram_addr   out  RAM_AW  RAM word address
//   ram_din    out  32      RAM write data
//   ram_we     out  1       RAM write strobe
//   ram_dout   in   32      RAM read data
//   sw_in      in   16      switches
//   led_out    out  16      LED register
//   bus_err    out  1       sticky unmapped-access flag
// ============================================================================
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_LAT = 2,
    parameter int          RAM_AW  = 10,
    parameter logic [31:0] IO_BASE = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Data_out,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              bus_err
);

    localparam logic [3:0] WCNT_INIT = 4'(RAM_LAT - 1);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [3:0]  wcnt;
    logic [3:0]  wcnt_nx;
    target_e     target;
    target_e     req_target;
    logic        is_write;
    logic        is_write_nx;
    logic        req;
    logic        ram_we_nx;
    logic        cnt_load;
    logic [31:0] count;

    assign req        = CPU_MIO & (MemRead | MemWrite);
    assign req_target = addr_decode(Addr_in, IO_BASE, RAM_AW);

    // Next-state and wait-counter logic
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (req_target == TGT_RAM) begin
                        state_nx = ST_RAM_WAIT;
                        wcnt_nx  = WCNT_INIT;
                    end else begin
                        state_nx = ST_IO_ACC;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RAM_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nx = ST_DONE;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            ST_IO_ACC: state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Direction of the access in the next cycle: captured once in IDLE,
    // then held so a CPU changing MemRead/MemWrite mid-access has no effect.
    always_comb begin
        if (state == ST_IDLE) begin
            is_write_nx = MemWrite;
        end else begin
            is_write_nx = is_write;
        end
    end

    // Write strobe is registered: it lands exactly in the wcnt==0 cycle
    assign ram_we_nx = (state_nx == ST_RAM_WAIT) && (wcnt_nx == 4'd0) && is_write_nx;

    // Counter reload happens on the single IO_ACC cycle of a counter write
    assign cnt_load = (state == ST_IO_ACC) && is_write && (target == TGT_CNT);

    mio_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (ram_din),
        .count    (count)
    );

    // FSM, request latches, read data and LED register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            target    <= TGT_NONE;
            is_write  <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= 32'd0;
            ram_we    <= 1'b0;
            Data_out  <= 32'd0;
            MIO_ready <= 1'b0;
            led_out   <= 16'd0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            is_write  <= is_write_nx;
            ram_we    <= ram_we_nx;
            // Ready follows the DONE cycle so it coincides with IDLE
            MIO_ready <= (state == ST_DONE);
            // ram_din doubles as the latched write data for IO writes
            if ((state == ST_IDLE) && req) begin
                target   <= req_target;
                ram_addr <= Addr_in[RAM_AW+1:2];
                ram_din  <= Data_in;
            end
            if ((state == ST_RAM_WAIT) && (wcnt == 4'd0) && !is_write) begin
                Data_out <= ram_dout;
            end
            if (state == ST_IO_ACC) begin
                case (target)
                    TGT_SW_LED: begin
                        if (is_write) begin
                            led_out <= ram_din[15:0];
                        end else begin
                            Data_out <= {16'd0, sw_in};
                        end
                    end
                    TGT_CNT: begin
                        if (!is_write) begin
                            Data_out <= count;
                        end
                    end
                    TGT_NONE: begin
                        if (!is_write) begin
                            Data_out <= 32'd0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef MIO_BUS_ERR_EN
    // Sticky error flag, raised when an unmapped access completes
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if ((state == ST_DONE) && (target == TGT_NONE)) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule
